// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard/stall controller with mul/div busy sequencing
module pipe_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  // md_cnt only ever holds MULDIV_CYCLES-2 (at most 30), so 5 bits suffice
  localparam int MD_W = 5;

  typedef enum logic {RUN, BUSY} state_t;

  state_t          state;
  logic [MD_W-1:0] md_cnt;
  logic            load_use;

  // register 0 is never a real producer, so a load to it cannot create a hazard
  assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  // combinational pipeline controls, highest-priority condition first
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else if (state == BUSY) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
      md_busy      = 1'b1;
    end else if (ex_muldiv_start) begin
      // the op stays in EX; a coincident branch is not a legal combination
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // the ID instruction is wrong-path, so any load-use match is irrelevant
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
    end
  end

  // mul/div occupancy FSM: start cycle plus MULDIV_CYCLES-1 BUSY cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_muldiv_start) begin
            state  <= BUSY;
            md_cnt <= MD_W'(MULDIV_CYCLES - 2);
          end
        end
        BUSY: begin
          if (md_cnt == '0) begin
            state <= RUN;
          end else begin
            md_cnt <= md_cnt - 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase
    end
  end

  // saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int MDC = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, idex_rt;
  logic          id_uses_rt, idex_mem_read, ex_branch_taken, ex_muldiv_start;
  logic          pc_write, ifid_write, ifid_flush, idex_write;
  logic          idex_bubble, exmem_bubble, md_busy;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_rt = 5'd0;
    ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pc0_cnt, busy_cnt;

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    // T1 reset
    check("rst_pc_write", pc_write, 0);
    check("rst_idex_bubble", idex_bubble, 1);
    check("rst_ifid_flush", ifid_flush, 1);
    check("rst_exmem_bubble", exmem_bubble, 1);
    check("rst_md_busy", md_busy, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t1_pc_write", pc_write, 1);
    check("t1_idex_write", idex_write, 1);
    check("t1_stall_count", stall_count, 0);

    // T2 load-use on rs
    idex_mem_read = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
    #1;
    check("t2_pc_write", pc_write, 0);
    check("t2_ifid_write", ifid_write, 0);
    check("t2_idex_write", idex_write, 1);
    check("t2_idex_bubble", idex_bubble, 1);
    tick();
    idle_inputs();
    #1;
    check("t2_stall_count", stall_count, 1);
    check("t2_release", pc_write, 1);

    // T3 no-hazard cases, and rt match when rt is used
    idex_mem_read = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    #1;
    check("t3_rt0_pc_write", pc_write, 1);
    check("t3_rt0_bubble", idex_bubble, 0);
    idex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    check("t3_rt_unused", pc_write, 1);
    id_uses_rt = 1'b1;
    #1;
    check("t3_rt_used", pc_write, 0);
    idex_mem_read = 1'b0;
    #1;
    check("t3_not_load", pc_write, 1);
    idle_inputs();
    tick();
    check("t3_stall_count", stall_count, 1);

    // T4 mul/div occupancy with a branch raised mid-BUSY
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t4_count_clear", stall_count, 0);
    pc0_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      ex_muldiv_start = (c == 0);
      ex_branch_taken = (c == 3);
      #1;
      if (c == 0) check("t4_start_not_busy", md_busy, 0);
      if (c == 0) check("t4_start_exmem_bubble", exmem_bubble, 1);
      if (c == 3) check("t4_branch_ignored_flush", ifid_flush, 0);
      if (c == 3) check("t4_branch_ignored_pc", pc_write, 0);
      if (c == MDC) check("t4_back_to_run", pc_write, 1);
      if (!pc_write) pc0_cnt++;
      if (md_busy) busy_cnt++;
      tick();
    end
    idle_inputs();
    check("t4_pc_write_zero_cycles", pc0_cnt, MDC);
    check("t4_md_busy_cycles", busy_cnt, MDC - 1);
    check("t4_stall_count", stall_count, MDC);

    // T5 branch wins over load-use
    ex_branch_taken = 1'b1; idex_mem_read = 1'b1; idex_rt = 5'd9; id_rs = 5'd9;
    #1;
    check("t5_ifid_flush", ifid_flush, 1);
    check("t5_idex_bubble", idex_bubble, 1);
    check("t5_pc_write", pc_write, 1);
    check("t5_ifid_write", ifid_write, 1);
    tick();
    idle_inputs();
    check("t5_stall_count", stall_count, MDC);

    // T6 reset on the 3rd BUSY cycle abandons the op
    ex_muldiv_start = 1'b1;
    tick();
    ex_muldiv_start = 1'b0;
    tick();
    tick();
    #1;
    check("t6_busy_before_rst", md_busy, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_forces_md_busy", md_busy, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_md_busy", md_busy, 0);
    check("t6_pc_write", pc_write, 1);
    check("t6_stall_count", stall_count, 0);

    // saturation: 20 held cycles on a 4-bit counter
    idex_mem_read = 1'b1; idex_rt = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1; id_rs = 5'd1;
    for (int c = 0; c < 20; c++) tick();
    check("t6_saturate", stall_count, 15);
    check("t6_still_stalled", pc_write, 0);
    idle_inputs();
    tick();
    check("t6_hold_at_max", stall_count, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
